fir_ctrl: RTL

FIR_CTRL -- requirements
Module: fir_ctrl

---
 rtl/fir_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/fir_ctrl.sv
// Control FSM for a tap-serial FIR: sequences tap/data RAM addresses, accumulator
// strobes and the AXI-stream handshakes; status bits mirror AXI-lite register 0x00.
module fir_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pMAX_TAP    = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   ap_start_set,
  input  logic                   sts_rd,
  input  logic [31:0]            data_length,
  input  logic [5:0]             tap_num,
  output logic                   ap_start,
  output logic                   ap_done,
  output logic                   ap_idle,
  output logic                   cfg_busy,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  input  logic                   sm_tready,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  output logic [pADDR_WIDTH-1:0] tap_addr,
  output logic [pADDR_WIDTH-1:0] data_addr,
  output logic                   data_we,
  output logic                   mac_clr,
  output logic                   mac_en
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_WAIT_IN, S_MAC, S_FLUSH, S_OUT, S_DONE
  } state_t;

  state_t      r_state;
  logic [5:0]  r_k;
  logic [5:0]  r_head;
  logic [5:0]  r_taps;
  logic [31:0] r_cnt;
  logic [31:0] r_len;
  logic        r_start, r_done, r_idle, r_mac_en;

  logic        w_cfg_ok;
  logic        w_last;
  logic [5:0]  w_mac_idx;
  logic        w_unused_tlast;

  // Run length comes only from the latched data_length.
  assign w_unused_tlast = ss_tlast;

  assign w_cfg_ok  = (tap_num != 6'd0) && (32'(tap_num) <= pMAX_TAP) && (data_length != 32'd0);
  assign w_last    = (r_cnt == r_len - 32'd1);
  // Circular buffer: newest sample at head, older samples walk backwards modulo tap count.
  assign w_mac_idx = (r_head >= r_k) ? (r_head - r_k) : (r_head + r_taps - r_k);

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_head   <= '0;
      r_taps   <= '0;
      r_cnt    <= '0;
      r_len    <= '0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_idle   <= 1'b1;
      r_mac_en <= 1'b0;
    end else begin
      // RAM read data lands one cycle after each MAC address cycle.
      r_mac_en <= (r_state == S_MAC);
      case (r_state)
        S_IDLE: begin
          if (ap_start_set && w_cfg_ok) begin
            r_taps  <= tap_num;
            r_len   <= data_length;
            r_start <= 1'b1;
            r_done  <= 1'b0;
            r_idle  <= 1'b0;
            r_k     <= '0;
            r_head  <= '0;
            r_cnt   <= '0;
            r_state <= S_INIT;
          end else if (sts_rd) begin
            r_done <= 1'b0;
          end
        end
        S_INIT: begin
          if (r_k == r_taps - 6'd1) begin
            r_k     <= '0;
            r_head  <= '0;
            r_cnt   <= '0;
            r_state <= S_WAIT_IN;
          end else begin
            r_k <= r_k + 6'd1;
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            r_k     <= '0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_k == r_taps - 6'd1) r_state <= S_FLUSH;
          else                      r_k     <= r_k + 6'd1;
        end
        S_FLUSH: r_state <= S_OUT;
        S_OUT: begin
          if (sm_tready) begin
            r_head <= (r_head == r_taps - 6'd1) ? 6'd0 : r_head + 6'd1;
            r_cnt  <= r_cnt + 32'd1;
            if (w_last) begin
              r_start <= 1'b0;
              r_done  <= 1'b1;
              r_idle  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT_IN;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ap_start = r_start;
  assign ap_done  = r_done;
  assign ap_idle  = r_idle;
  assign mac_en   = r_mac_en;
  assign cfg_busy = (r_state != S_IDLE);

  always_comb begin
    ss_tready = 1'b0;
    sm_tvalid = 1'b0;
    sm_tlast  = 1'b0;
    tap_addr  = '0;
    data_addr = '0;
    data_we   = 1'b0;
    mac_clr   = 1'b0;
    case (r_state)
      S_INIT: begin
        data_we   = 1'b1;
        data_addr = pADDR_WIDTH'({r_k, 2'b00});
      end
      S_WAIT_IN: begin
        ss_tready = 1'b1;
        data_we   = ss_tvalid;
        mac_clr   = ss_tvalid;
        data_addr = pADDR_WIDTH'({r_head, 2'b00});
      end
      S_MAC: begin
        tap_addr  = pADDR_WIDTH'({r_k, 2'b00});
        data_addr = pADDR_WIDTH'({w_mac_idx, 2'b00});
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = w_last;
      end
      default: ;
    endcase
  end

endmodule
